// File: rtl/vec_mem_engine.sv
// ============================================================================
// Module   : vec_mem_engine
// Purpose  : Vector load/store sequencer between the memory bus and the vector
//            register file. Optional macro VMEM_STRIDE_EN enables a latched
//            per-element address stride (otherwise the increment is fixed at 1).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_mem_engine #(
  parameter int ELEMS = 16,
  parameter int EW    = 16,
  parameter int AW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op,
  input  logic [AW-1:0]       base,
  input  logic [AW-1:0]       stride,
  input  logic [ELEMS*EW-1:0] vec_in,
  output logic [ELEMS*EW-1:0] vec_out,
  output logic                vec_wr,
  output logic                busy,
  output logic                done,
  output logic                addr_wrap,
  output logic [AW-1:0]       addr,
  output logic                rd,
  output logic                wr,
  output logic [EW-1:0]       data_out,
  input  logic [EW-1:0]       data_in,
  input  logic                mem_ready
);

  localparam int IW = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic                      op_q;
  logic [IW-1:0]             idx;
  logic [ELEMS-1:0][EW-1:0]  src_q;
  logic [ELEMS-1:0][EW-1:0]  load_buf;
  logic [ELEMS-1:0][EW-1:0]  load_full;
  logic [AW-1:0]             step;
  logic [AW:0]               addr_sum;
  logic                      accept;
  logic                      last;
  logic                      launch;

  assign launch   = (state == S_IDLE) && start;
  assign accept   = (state == S_REQ) && mem_ready;
  assign last     = (idx == IW'(ELEMS - 1));
  assign addr_sum = {1'b0, addr} + {1'b0, step};

`ifdef VMEM_STRIDE_EN
  logic [AW-1:0] stride_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stride_q <= '0;
    end else if (launch) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign step          = AW'(1);
`endif

  // Completed vector including the element arriving this cycle, so the final
  // accept can publish the whole vector without an extra cycle.
  always_comb begin
    load_full      = load_buf;
    load_full[idx] = data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   if (mem_ready && last) state_nxt = op_q ? S_DONE : S_WB;
      S_WB:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    rd     = (state == S_REQ) && !op_q;
    wr     = (state == S_REQ) && op_q;
    vec_wr = (state == S_WB);
    done   = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 1'b0;
      idx       <= '0;
      src_q     <= '0;
      load_buf  <= '0;
      addr      <= '0;
      data_out  <= '0;
      vec_out   <= '0;
      addr_wrap <= 1'b0;
    end else if (launch) begin
      op_q      <= op;
      src_q     <= vec_in;
      idx       <= '0;
      addr      <= base;
      data_out  <= vec_in[EW-1:0];
      addr_wrap <= 1'b0;
    end else if (accept) begin
      if (!op_q) begin
        load_buf <= load_full;
      end
      if (last) begin
        if (!op_q) begin
          vec_out <= load_full;
        end
      end else begin
        idx      <= idx + 1'b1;
        addr     <= addr_sum[AW-1:0];
        data_out <= src_q[idx + 1'b1];
        if (addr_sum[AW]) begin
          addr_wrap <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_engine.sv
// ============================================================================
// Module   : tb_vec_mem_engine
// Purpose  : Randomised self-checking bench for vec_mem_engine against an
//            arithmetic address/data reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vec_mem_engine;

  localparam int ELEMS = 16;
  localparam int EW    = 16;
  localparam int AW    = 16;
  localparam int VW    = ELEMS * EW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          op;
  logic [AW-1:0] base;
  logic [AW-1:0] stride;
  logic [VW-1:0] vec_in;
  logic [VW-1:0] vec_out;
  logic          vec_wr;
  logic          busy;
  logic          done;
  logic          addr_wrap;
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [EW-1:0] data_out;
  logic [EW-1:0] data_in;
  logic          mem_ready;

  int            total = 0;
  int            bad   = 0;
  logic [VW-1:0] last_vec = '0;

  always #5 clk = ~clk;

  vec_mem_engine #(.ELEMS(ELEMS), .EW(EW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .base(base),
    .stride(stride), .vec_in(vec_in), .vec_out(vec_out), .vec_wr(vec_wr),
    .busy(busy), .done(done), .addr_wrap(addr_wrap), .addr(addr), .rd(rd),
    .wr(wr), .data_out(data_out), .data_in(data_in), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned step_of(input logic [AW-1:0] s);
`ifdef VMEM_STRIDE_EN
    return longint'(s);
`else
    return (s == s) ? 64'd1 : 64'd1;
`endif
  endfunction

  function automatic logic [VW-1:0] all_outs();
    return VW'({busy, done, vec_wr, rd, wr, addr_wrap, addr, data_out}) | vec_out;
  endfunction

  // mode: 0 = always ready, 1 = random stalls, 2 = two stall cycles on element 5
  task automatic run_op(input bit o, input logic [AW-1:0] b, input logic [AW-1:0] s,
                        input logic [VW-1:0] v, input int mode, input bit spam, input int abort_at);
    logic [VW-1:0]   got_vec = '0;
    longint unsigned stp = step_of(s);
    longint unsigned a;
    bit              wrap_exp;
    bit              stall_now;
    int              k = 0;
    int              cyc = 0;
    int              stall = 0;
    start = 1'b1; op = o; base = b; stride = s; vec_in = v; mem_ready = 1'b0;
    @(negedge clk);
    if (spam) begin
      op = ~o; base = ~b; vec_in = ~v; stride = s + 3;
    end else begin
      start = 1'b0;
    end
    while (k < ELEMS && cyc < 1000) begin
      a = longint'(b) + longint'(k) * stp;
      check("busy", VW'(busy), VW'(1));
      check("rd", VW'(rd), VW'(!o));
      check("wr", VW'(wr), VW'(o));
      check("addr", VW'(addr), VW'(a % (64'd1 << AW)));
      check("wrap", VW'(addr_wrap), VW'(a >= (64'd1 << AW)));
      if (o) check("dout", VW'(data_out), VW'(v[k*EW +: EW]));
      check("vhold", vec_out, last_vec);
      check("vwr_mid", VW'(vec_wr), VW'(0));
      if (k == abort_at) begin
        reset = 1'b1; start = 1'b0;
        #1;
        check("abort_outs", all_outs(), '0);
        last_vec = '0;
        @(negedge clk);
        check("abort_hold", all_outs(), '0);
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        return;
      end
      stall_now = (mode == 2) && (k == 5) && (stall < 2);
      if (stall_now) stall++;
      mem_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : !stall_now;
      data_in   = (mode == 1) ? EW'($urandom) : EW'(16'hA000 + k);
      if (mem_ready) begin
        got_vec[k*EW +: EW] = data_in;
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    check("bound", VW'(k), VW'(ELEMS));
    if (mode == 0) check("latency", VW'(cyc), VW'(ELEMS));
    if (mode == 2) check("latency_stall", VW'(cyc), VW'(ELEMS + 2));
    mem_ready = 1'b0;
    if (!o) begin
      check("vwr", VW'(vec_wr), VW'(1));
      check("vec", vec_out, got_vec);
      check("rd_off", VW'(rd), VW'(0));
      check("done_early", VW'(done), VW'(0));
      last_vec = got_vec;
      @(negedge clk);
    end
    start = 1'b0;
    a = longint'(b) + longint'(ELEMS - 1) * stp;
    wrap_exp = (a >= (64'd1 << AW));
    check("done", VW'(done), VW'(1));
    check("busy_done", VW'(busy), VW'(1));
    check("bus_off", VW'({rd, wr, vec_wr}), VW'(0));
    check("wrap_final", VW'(addr_wrap), VW'(wrap_exp));
    @(negedge clk);
    check("idle", VW'({busy, done}), VW'(0));
    check("wrap_sticky", VW'(addr_wrap), VW'(wrap_exp));
    check("vec_keep", vec_out, last_vec);
  endtask

  initial begin
    logic [VW-1:0] v;
    reset = 1'b1; start = 1'b0; op = 1'b0; base = '0; stride = '0;
    vec_in = '0; data_in = '0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outs", all_outs(), '0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 16'h0100, 16'h0000, '0, 0, 1'b0, -1);
    for (int i = 0; i < ELEMS; i++) v[i*EW +: EW] = EW'(i * 3);
    run_op(1'b1, 16'h2000, 16'h0000, v, 2, 1'b0, -1);
    run_op(1'b0, 16'hFFF8, 16'h0002, '0, 0, 1'b0, -1);
    run_op(1'b0, 16'h0000, 16'h0005, '0, 0, 1'b0, -1);
    run_op(1'b0, 16'h0300, 16'h0001, '0, 1, 1'b1, -1);
    run_op(1'b0, 16'h0400, 16'h0001, '0, 0, 1'b0, 7);
    run_op(1'b0, 16'h0500, 16'h0001, '0, 0, 1'b0, -1);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
      run_op(1'(t % 2), AW'($urandom), AW'($urandom_range(0, 4096)), v, 1,
             1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
